// File: rtl/rv_alu2_if.sv
// rv_alu2_if: signal bundle between rv_alu1 (master side) and rv_alu2 (slave side).
//
// Direction is seen from rv_alu2:
//   i_flush / i_stall        : stage kill / stage hold
//   i_op1, i_op2             : operands
//   i_res                    : one-hot result group {arith, logic, shift, cmp}
//   i_alu_ctrl               : one-hot op {add, sub, xor_, or_, and_, sll, srl, sra, slt, sltu}
//   i_funct3                 : branch condition / memory size
//   i_res_src .. i_to_trap   : pass-through control, destination and store data
//   i_inst_jal_jalr, i_inst_branch, i_branch_pred : jump / branch / predicted-taken
//   i_pc, i_pc_next, i_pc_target                  : PC, fall-through PC, computed target
//   o_result .. o_funct3     : registered result and pass-through towards memory stage
//   o_pc_select, o_pc_new    : single-shot fetch redirect
//   o_to_trap                : trap request
//   o_dbg_pc, o_dbg_redirect_done : visibility of the instruction held in the stage
//
// Handshake: there is no valid/ready pair. The stage advances on every clock
// edge where i_stall is low; i_flush (like reset) kills the control fields on
// the next edge and takes priority over i_stall.
interface rv_alu2_if #(
  parameter int IADDR_SPACE_BITS = 32
);
  typedef struct packed {
    logic arith;
    logic logic_op;
    logic shift;
    logic cmp;
  } alu_res_t;

  typedef struct packed {
    logic add;
    logic sub;
    logic xor_;
    logic or_;
    logic and_;
    logic sll;
    logic srl;
    logic sra;
    logic slt;
    logic sltu;
  } alu_ctrl_t;

  logic                        i_flush;
  logic                        i_stall;
  logic [31:0]                 i_op1;
  logic [31:0]                 i_op2;
  alu_res_t                    i_res;
  alu_ctrl_t                   i_alu_ctrl;
  logic [2:0]                  i_funct3;
  logic [1:0]                  i_res_src;
  logic                        i_reg_write;
  logic                        i_store;
  logic [4:0]                  i_rd;
  logic [31:0]                 i_reg_data2;
  logic                        i_to_trap;
  logic                        i_inst_jal_jalr;
  logic                        i_inst_branch;
  logic                        i_branch_pred;
  logic [IADDR_SPACE_BITS-1:0] i_pc;
  logic [IADDR_SPACE_BITS-1:0] i_pc_next;
  logic [IADDR_SPACE_BITS-1:0] i_pc_target;

  logic [31:0]                 o_result;
  logic [31:0]                 o_store_data;
  logic [4:0]                  o_rd;
  logic                        o_reg_write;
  logic                        o_store;
  logic [1:0]                  o_res_src;
  logic [2:0]                  o_funct3;
  logic                        o_pc_select;
  logic [IADDR_SPACE_BITS-1:0] o_pc_new;
  logic                        o_to_trap;
  logic [IADDR_SPACE_BITS-1:0] o_dbg_pc;
  logic                        o_dbg_redirect_done;

  modport master (
    output i_flush, i_stall, i_op1, i_op2, i_res, i_alu_ctrl, i_funct3,
           i_res_src, i_reg_write, i_store, i_rd, i_reg_data2, i_to_trap,
           i_inst_jal_jalr, i_inst_branch, i_branch_pred,
           i_pc, i_pc_next, i_pc_target,
    input  o_result, o_store_data, o_rd, o_reg_write, o_store, o_res_src,
           o_funct3, o_pc_select, o_pc_new, o_to_trap,
           o_dbg_pc, o_dbg_redirect_done
  );

  modport slave (
    input  i_flush, i_stall, i_op1, i_op2, i_res, i_alu_ctrl, i_funct3,
           i_res_src, i_reg_write, i_store, i_rd, i_reg_data2, i_to_trap,
           i_inst_jal_jalr, i_inst_branch, i_branch_pred,
           i_pc, i_pc_next, i_pc_target,
    output o_result, o_store_data, o_rd, o_reg_write, o_store, o_res_src,
           o_funct3, o_pc_select, o_pc_new, o_to_trap,
           o_dbg_pc, o_dbg_redirect_done
  );
endinterface

// File: rtl/rv_alu2.sv
// rv_alu2: second execute stage of FlexRV32.
//
// Registers everything rv_alu1 hands over, computes the integer ALU result,
// resolves branches/jumps against the front-end prediction and raises a
// single-shot fetch redirect on misprediction.
//
// Ports:
//   i_clk      : clock
//   i_reset_n  : synchronous active-low reset
//   bus        : rv_alu2_if.slave, all stage inputs and outputs (see interface)
module rv_alu2 #(
  parameter int IADDR_SPACE_BITS = 32
) (
  input logic     i_clk,
  input logic     i_reset_n,
  rv_alu2_if.slave bus
);
  localparam int N = IADDR_SPACE_BITS;

  // Bit positions inside the one-hot vectors (MSB is the first listed member).
  localparam int R_ARITH = 3;
  localparam int R_LOGIC = 2;
  localparam int R_SHIFT = 1;
  localparam int R_CMP   = 0;

  localparam int C_ADD  = 9;
  localparam int C_SUB  = 8;
  localparam int C_XOR  = 7;
  localparam int C_OR   = 6;
  localparam int C_AND  = 5;
  localparam int C_SLL  = 4;
  localparam int C_SRL  = 3;
  localparam int C_SRA  = 2;
  localparam int C_SLT  = 1;
  localparam int C_SLTU = 0;

  // ---------------------------------------------------------------------------
  // Stage registers: control fields (cleared by reset/flush)
  // ---------------------------------------------------------------------------
  logic [4:0]   rd_q,            rd_d;
  logic         reg_write_q,     reg_write_d;
  logic         store_q,         store_d;
  logic [1:0]   res_src_q,       res_src_d;
  logic         jal_q,           jal_d;
  logic         branch_q,        branch_d;
  logic         pred_q,          pred_d;
  logic         to_trap_q,       to_trap_d;
  logic         redirect_done_q, redirect_done_d;

  // Stage registers: data fields (never cleared)
  logic [31:0]  op1_q,        op1_d;
  logic [31:0]  op2_q,        op2_d;
  logic [3:0]   res_q,        res_d;
  logic [9:0]   ctrl_q,       ctrl_d;
  logic [2:0]   funct3_q,     funct3_d;
  logic [31:0]  store_data_q, store_data_d;
  logic [N-1:0] pc_q,         pc_d;
  logic [N-1:0] pc_next_q,    pc_next_d;
  logic [N-1:0] pc_target_q,  pc_target_d;

  logic         pc_select;

  // ---------------------------------------------------------------------------
  // Next-state for the stage registers
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_d            = rd_q;
    reg_write_d     = reg_write_q;
    store_d         = store_q;
    res_src_d       = res_src_q;
    jal_d           = jal_q;
    branch_d        = branch_q;
    pred_d          = pred_q;
    to_trap_d       = to_trap_q;
    redirect_done_d = redirect_done_q;

    op1_d        = op1_q;
    op2_d        = op2_q;
    res_d        = res_q;
    ctrl_d       = ctrl_q;
    funct3_d     = funct3_q;
    store_data_d = store_data_q;
    pc_d         = pc_q;
    pc_next_d    = pc_next_q;
    pc_target_d  = pc_target_q;

    if (bus.i_flush) begin
      rd_d            = '0;
      reg_write_d     = 1'b0;
      store_d         = 1'b0;
      res_src_d       = '0;
      jal_d           = 1'b0;
      branch_d        = 1'b0;
      pred_d          = 1'b0;
      to_trap_d       = 1'b0;
      redirect_done_d = 1'b0;
    end else if (!bus.i_stall) begin
      rd_d            = bus.i_rd;
      reg_write_d     = bus.i_reg_write;
      store_d         = bus.i_store;
      res_src_d       = bus.i_res_src;
      jal_d           = bus.i_inst_jal_jalr;
      branch_d        = bus.i_inst_branch;
      pred_d          = bus.i_branch_pred;
      to_trap_d       = bus.i_to_trap;
      redirect_done_d = 1'b0;

      op1_d        = bus.i_op1;
      op2_d        = bus.i_op2;
      res_d        = bus.i_res;
      ctrl_d       = bus.i_alu_ctrl;
      funct3_d     = bus.i_funct3;
      store_data_d = bus.i_reg_data2;
      pc_d         = bus.i_pc;
      pc_next_d    = bus.i_pc_next;
      pc_target_d  = bus.i_pc_target;
    end else if (pc_select) begin
      // The instruction is held by a stall: remember that its redirect has
      // already been issued so the pulse is not repeated next cycle.
      redirect_done_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rd_q            <= '0;
      reg_write_q     <= 1'b0;
      store_q         <= 1'b0;
      res_src_q       <= '0;
      jal_q           <= 1'b0;
      branch_q        <= 1'b0;
      pred_q          <= 1'b0;
      to_trap_q       <= 1'b0;
      redirect_done_q <= 1'b0;
    end else begin
      rd_q            <= rd_d;
      reg_write_q     <= reg_write_d;
      store_q         <= store_d;
      res_src_q       <= res_src_d;
      jal_q           <= jal_d;
      branch_q        <= branch_d;
      pred_q          <= pred_d;
      to_trap_q       <= to_trap_d;
      redirect_done_q <= redirect_done_d;
    end
  end

  // Data fields keep their contents through reset.
  always_ff @(posedge i_clk) begin
    if (i_reset_n) begin
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      res_q        <= res_d;
      ctrl_q       <= ctrl_d;
      funct3_q     <= funct3_d;
      store_data_q <= store_data_d;
      pc_q         <= pc_d;
      pc_next_q    <= pc_next_d;
      pc_target_q  <= pc_target_d;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU: one-hot AND-OR selection inside each group, then across groups
  // ---------------------------------------------------------------------------
  logic [31:0] sum, diff, r_arith, r_logic, r_shift, r_cmp, alu_out;
  logic [4:0]  shamt;
  logic        lt_s, lt_u;

  always_comb begin
    shamt = op2_q[4:0];
    sum   = op1_q + op2_q;
    diff  = op1_q - op2_q;
    lt_s  = $signed(op1_q) < $signed(op2_q);
    lt_u  = op1_q < op2_q;

    r_arith = ({32{ctrl_q[C_ADD]}} & sum)
            | ({32{ctrl_q[C_SUB]}} & diff);
    r_logic = ({32{ctrl_q[C_XOR]}} & (op1_q ^ op2_q))
            | ({32{ctrl_q[C_OR]}}  & (op1_q | op2_q))
            | ({32{ctrl_q[C_AND]}} & (op1_q & op2_q));
    r_shift = ({32{ctrl_q[C_SLL]}} & (op1_q << shamt))
            | ({32{ctrl_q[C_SRL]}} & (op1_q >> shamt))
            | ({32{ctrl_q[C_SRA]}} & 32'($signed(op1_q) >>> shamt));
    r_cmp   = ({32{ctrl_q[C_SLT]}}  & {31'b0, lt_s})
            | ({32{ctrl_q[C_SLTU]}} & {31'b0, lt_u});

    alu_out = ({32{res_q[R_ARITH]}} & r_arith)
            | ({32{res_q[R_LOGIC]}} & r_logic)
            | ({32{res_q[R_SHIFT]}} & r_shift)
            | ({32{res_q[R_CMP]}}   & r_cmp);
  end

  // ---------------------------------------------------------------------------
  // Branch resolution and redirect
  // ---------------------------------------------------------------------------
  logic         cond, taken, mispredict, misalign, trap;
  logic [N-1:0] pc_new;

  always_comb begin
    cond = 1'b0;
    unique case (funct3_q)
      3'b000:  cond = (op1_q == op2_q);
      3'b001:  cond = (op1_q != op2_q);
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;
    endcase

    taken      = jal_q | (branch_q & cond);
    mispredict = (branch_q | jal_q) & (taken != pred_q);
    // Bit 0 of the target is dropped so jalr targets are always even.
    pc_new     = taken ? (pc_target_q & ~{{(N-1){1'b0}}, 1'b1}) : pc_next_q;
    misalign   = taken & pc_new[1];
    trap       = to_trap_q | misalign;
    pc_select  = mispredict & !misalign & !to_trap_q & !redirect_done_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_result            = jal_q ? 32'(pc_next_q) : alu_out;
    bus.o_store_data        = store_data_q;
    bus.o_rd                = rd_q;
    bus.o_reg_write         = reg_write_q & !trap;
    bus.o_store             = store_q & !trap;
    bus.o_res_src           = res_src_q;
    bus.o_funct3            = funct3_q;
    bus.o_pc_select         = pc_select;
    bus.o_pc_new            = pc_new;
    bus.o_to_trap           = trap;
    bus.o_dbg_pc            = pc_q;
    bus.o_dbg_redirect_done = redirect_done_q;
  end

endmodule

// File: tb/tb_rv_alu2.sv
// Testbench for rv_alu2: reset check, table-driven ALU vectors, hand-written
// branch/jump/stall/flush sequences and a randomized run against a reference
// model computed directly from the ISA rules.
module tb_rv_alu2;
  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic i_clk;
  logic i_reset_n;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  rv_alu2_if #(.IADDR_SPACE_BITS(32)) bus ();

  rv_alu2 #(.IADDR_SPACE_BITS(32)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  // One-hot encodings, first listed member is the MSB.
  localparam logic [3:0] R_ARITH = 4'b1000;
  localparam logic [3:0] R_LOGIC = 4'b0100;
  localparam logic [3:0] R_SHIFT = 4'b0010;
  localparam logic [3:0] R_CMP   = 4'b0001;

  localparam logic [9:0] C_ADD  = 10'b10_0000_0000;
  localparam logic [9:0] C_SUB  = 10'b01_0000_0000;
  localparam logic [9:0] C_XOR  = 10'b00_1000_0000;
  localparam logic [9:0] C_OR   = 10'b00_0100_0000;
  localparam logic [9:0] C_AND  = 10'b00_0010_0000;
  localparam logic [9:0] C_SLL  = 10'b00_0001_0000;
  localparam logic [9:0] C_SRL  = 10'b00_0000_1000;
  localparam logic [9:0] C_SRA  = 10'b00_0000_0100;
  localparam logic [9:0] C_SLT  = 10'b00_0000_0010;
  localparam logic [9:0] C_SLTU = 10'b00_0000_0001;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.i_flush         = 1'b0;
    bus.i_stall         = 1'b0;
    bus.i_op1           = '0;
    bus.i_op2           = '0;
    bus.i_res           = R_ARITH;
    bus.i_alu_ctrl      = C_ADD;
    bus.i_funct3        = 3'b000;
    bus.i_res_src       = 2'b00;
    bus.i_reg_write     = 1'b0;
    bus.i_store         = 1'b0;
    bus.i_rd            = '0;
    bus.i_reg_data2     = '0;
    bus.i_to_trap       = 1'b0;
    bus.i_inst_jal_jalr = 1'b0;
    bus.i_inst_branch   = 1'b0;
    bus.i_branch_pred   = 1'b0;
    bus.i_pc            = '0;
    bus.i_pc_next       = '0;
    bus.i_pc_target     = '0;
  endtask

  task automatic drive_alu(input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] res, input logic [9:0] ctrl);
    drive_idle();
    bus.i_op1       = a;
    bus.i_op2       = b;
    bus.i_res       = res;
    bus.i_alu_ctrl  = ctrl;
    bus.i_reg_write = 1'b1;
    bus.i_rd        = 5'd1;
  endtask

  task automatic drive_cf(input logic jal, input logic br, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic pred, input logic [31:0] pc,
                          input logic [31:0] pc_next, input logic [31:0] tgt,
                          input logic rw, input logic [4:0] rd);
    drive_idle();
    bus.i_inst_jal_jalr = jal;
    bus.i_inst_branch   = br;
    bus.i_funct3        = f3;
    bus.i_op1           = a;
    bus.i_op2           = b;
    bus.i_branch_pred   = pred;
    bus.i_pc            = pc;
    bus.i_pc_next       = pc_next;
    bus.i_pc_target     = tgt;
    bus.i_reg_write     = rw;
    bus.i_rd            = rd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (ISA rules in plain arithmetic)
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    int sh;
    sh = int'(b % 32);
    case (op)
      0: r = a + b;
      1: r = a - b;
      2: r = a ^ b;
      3: r = a | b;
      4: r = a & b;
      5: r = a << sh;
      6: r = a >> sh;
      7: begin
        r = a >> sh;
        if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
      end
      8: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    logic slt;
    slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return slt;
      3'd5: return !slt;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Expected record: {result, pc_sel, pc_new, trap, reg_write, store, rd, store_data}
  localparam int EW = 32 + 1 + 32 + 1 + 1 + 1 + 5 + 32;
  logic [EW-1:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // ALU vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  res;
    logic [9:0]  ctrl;
    logic [31:0] exp;
  } alu_vec_t;

  alu_vec_t vecs[12];

  initial begin
    logic [EW-1:0] e;
    logic [31:0] e_res, e_new, e_sd;
    logic e_sel, e_trap, e_rw, e_st;
    logic [4:0] e_rd;

    vecs[0]  = '{"sub_5_7",   32'd5,          32'd7,          R_ARITH, C_SUB,  32'hFFFF_FFFE};
    vecs[1]  = '{"add_wrap",  32'hFFFF_FFFF,  32'd2,          R_ARITH, C_ADD,  32'h0000_0001};
    vecs[2]  = '{"xor",       32'hF0F0_F0F0,  32'hFF00_FF00,  R_LOGIC, C_XOR,  32'h0FF0_0FF0};
    vecs[3]  = '{"or",        32'h1234_0000,  32'h0000_5678,  R_LOGIC, C_OR,   32'h1234_5678};
    vecs[4]  = '{"and",       32'hF0F0_F0F0,  32'h0FF0_0FF0,  R_LOGIC, C_AND,  32'h00F0_00F0};
    vecs[5]  = '{"sll_hi",    32'h0000_0003,  32'h0000_0021,  R_SHIFT, C_SLL,  32'h0000_0006};
    vecs[6]  = '{"srl_31",    32'h8000_0000,  32'd31,         R_SHIFT, C_SRL,  32'h0000_0001};
    vecs[7]  = '{"sra_31",    32'h8000_0000,  32'd31,         R_SHIFT, C_SRA,  32'hFFFF_FFFF};
    vecs[8]  = '{"sra_pos",   32'h4000_0000,  32'd4,          R_SHIFT, C_SRA,  32'h0400_0000};
    vecs[9]  = '{"sltu_1_ff", 32'd1,          32'hFFFF_FFFF,  R_CMP,   C_SLTU, 32'd1};
    vecs[10] = '{"slt_1_ff",  32'd1,          32'hFFFF_FFFF,  R_CMP,   C_SLT,  32'd0};
    vecs[11] = '{"slt_neg",   32'hFFFF_FFFF,  32'd1,          R_CMP,   C_SLT,  32'd1};

    // ---- reset with non-zero inputs ----
    drive_cf(1'b1, 1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 32'h100, 32'h104, 32'h143, 1'b1, 5'd31);
    bus.i_store   = 1'b1;
    bus.i_res_src = 2'b11;
    bus.i_to_trap = 1'b1;
    bus.i_stall   = 1'b1;
    i_reset_n = 1'b0;
    step();
    step();
    chk("rst_rd",        32'(bus.o_rd),        32'd0);
    chk("rst_reg_write", 32'(bus.o_reg_write), 32'd0);
    chk("rst_store",     32'(bus.o_store),     32'd0);
    chk("rst_res_src",   32'(bus.o_res_src),   32'd0);
    chk("rst_pc_select", 32'(bus.o_pc_select), 32'd0);
    chk("rst_to_trap",   32'(bus.o_to_trap),   32'd0);
    i_reset_n = 1'b1;
    drive_idle();
    step();

    // ---- ALU vectors ----
    for (int i = 0; i < 12; i++) begin
      drive_alu(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ctrl);
      step();
      chk(vecs[i].name, bus.o_result, vecs[i].exp);
    end
    chk("alu_rd", 32'(bus.o_rd), 32'd1);

    // ---- BEQ taken, predicted not taken: one redirect ----
    drive_cf(1'b0, 1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 32'h100, 32'h104, 32'h140, 1'b0, 5'd0);
    step();
    chk("beq_sel", 32'(bus.o_pc_select), 32'd1);
    chk("beq_new", bus.o_pc_new, 32'h140);
    drive_idle();
    step();
    chk("beq_sel_after", 32'(bus.o_pc_select), 32'd0);

    // ---- BNE equal operands, predicted taken: redirect to fall-through ----
    drive_cf(1'b0, 1'b1, 3'd1, 32'd3, 32'd3, 1'b1, 32'h100, 32'h104, 32'h140, 1'b0, 5'd0);
    step();
    chk("bne_sel", 32'(bus.o_pc_select), 32'd1);
    chk("bne_new", bus.o_pc_new, 32'h104);
    drive_cf(1'b0, 1'b1, 3'd1, 32'd3, 32'd3, 1'b0, 32'h100, 32'h104, 32'h140, 1'b0, 5'd0);
    step();
    chk("bne_nt_sel", 32'(bus.o_pc_select), 32'd0);

    // ---- JALR misaligned target ----
    drive_cf(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h104, 32'h108, 32'h203, 1'b1, 5'd1);
    step();
    chk("jalr_mis_new",  bus.o_pc_new, 32'h202);
    chk("jalr_mis_trap", 32'(bus.o_to_trap), 32'd1);
    chk("jalr_mis_sel",  32'(bus.o_pc_select), 32'd0);
    chk("jalr_mis_rw",   32'(bus.o_reg_write), 32'd0);
    drive_cf(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 32'h104, 32'h108, 32'h201, 1'b1, 5'd1);
    step();
    chk("jalr_new",    bus.o_pc_new, 32'h200);
    chk("jalr_sel",    32'(bus.o_pc_select), 32'd1);
    chk("jalr_result", bus.o_result, 32'h108);
    chk("jalr_rw",     32'(bus.o_reg_write), 32'd1);
    chk("jalr_trap",   32'(bus.o_to_trap), 32'd0);

    // ---- mispredicted branch held by a 3-cycle stall, then flush ----
    drive_cf(1'b0, 1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 32'h100, 32'h104, 32'h140, 1'b1, 5'd3);
    step();
    chk("stall_c1_sel", 32'(bus.o_pc_select), 32'd1);
    drive_cf(1'b0, 1'b0, 3'd1, 32'd9, 32'd4, 1'b1, 32'h500, 32'h504, 32'h600, 1'b0, 5'd9);
    bus.i_stall = 1'b1;
    step();
    chk("stall_c2_sel", 32'(bus.o_pc_select), 32'd0);
    chk("stall_c2_new", bus.o_pc_new, 32'h140);
    chk("stall_c2_rd",  32'(bus.o_rd), 32'd3);
    step();
    chk("stall_c3_sel", 32'(bus.o_pc_select), 32'd0);
    chk("stall_c3_rw",  32'(bus.o_reg_write), 32'd1);
    bus.i_flush = 1'b1;
    step();
    chk("flush_rd", 32'(bus.o_rd), 32'd0);
    chk("flush_rw", 32'(bus.o_reg_write), 32'd0);
    chk("flush_sel", 32'(bus.o_pc_select), 32'd0);

    // ---- flush in the same cycle as a redirect ----
    drive_cf(1'b0, 1'b1, 3'd0, 32'd3, 32'd3, 1'b0, 32'h100, 32'h104, 32'h140, 1'b1, 5'd4);
    step();
    chk("fr_sel", 32'(bus.o_pc_select), 32'd1);
    bus.i_flush = 1'b1;
    step();
    chk("fr_sel_after", 32'(bus.o_pc_select), 32'd0);
    chk("fr_rd", 32'(bus.o_rd), 32'd0);

    // ---- reset asserted mid-stall ----
    drive_alu(32'd1, 32'd1, R_ARITH, C_ADD);
    bus.i_rd = 5'd7;
    step();
    bus.i_stall = 1'b1;
    step();
    chk("mid_stall_rd", 32'(bus.o_rd), 32'd7);
    i_reset_n = 1'b0;
    step();
    chk("mid_rst_rd", 32'(bus.o_rd), 32'd0);
    chk("mid_rst_rw", 32'(bus.o_reg_write), 32'd0);
    i_reset_n = 1'b1;
    drive_idle();
    step();

    // ---- randomized run against the reference model ----
    for (int n = 0; n < 400; n++) begin
      int op;
      logic [31:0] a, b, pn, tg;
      logic jal, br, pred, trp, tk;
      logic [2:0] f3;
      op  = int'($urandom_range(0, 9));
      a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      br  = 1'($urandom_range(0, 1));
      jal = !br && ($urandom_range(0, 2) == 0);
      f3  = 3'($urandom_range(0, 7));
      pred = 1'($urandom_range(0, 1));
      trp = ($urandom_range(0, 7) == 0);
      pn  = $urandom & 32'hFFFF_FFFC;
      tg  = $urandom;
      drive_idle();
      bus.i_op1           = a;
      bus.i_op2           = b;
      bus.i_alu_ctrl      = 10'b10_0000_0000 >> op;
      bus.i_res           = (op < 2) ? R_ARITH : (op < 5) ? R_LOGIC : (op < 8) ? R_SHIFT : R_CMP;
      bus.i_funct3        = f3;
      bus.i_inst_branch   = br;
      bus.i_inst_jal_jalr = jal;
      bus.i_branch_pred   = pred;
      bus.i_to_trap       = trp;
      bus.i_pc            = pn - 32'd4;
      bus.i_pc_next       = pn;
      bus.i_pc_target     = tg;
      bus.i_reg_write     = 1'($urandom_range(0, 1));
      bus.i_store         = 1'($urandom_range(0, 1));
      bus.i_rd            = 5'($urandom_range(0, 31));
      bus.i_reg_data2     = $urandom;

      tk     = jal || (br && ref_cond(f3, a, b));
      e_new  = tk ? {tg[31:1], 1'b0} : pn;
      e_trap = trp || (tk && e_new[1]);
      e_sel  = (br || jal) && (tk != pred) && !e_trap;
      e_res  = jal ? pn : ref_alu(op, a, b);
      e_rw   = bus.i_reg_write && !e_trap;
      e_st   = bus.i_store && !e_trap;
      e_rd   = bus.i_rd;
      e_sd   = bus.i_reg_data2;
      exp_q.push_back({e_res, e_sel, e_new, e_trap, e_rw, e_st, e_rd, e_sd});

      step();
      e = exp_q.pop_front();
      {e_res, e_sel, e_new, e_trap, e_rw, e_st, e_rd, e_sd} = e;
      chk("rnd_result",     bus.o_result,              e_res);
      chk("rnd_pc_select",  32'(bus.o_pc_select),      32'(e_sel));
      chk("rnd_pc_new",     bus.o_pc_new,              e_new);
      chk("rnd_to_trap",    32'(bus.o_to_trap),        32'(e_trap));
      chk("rnd_reg_write",  32'(bus.o_reg_write),      32'(e_rw));
      chk("rnd_store",      32'(bus.o_store),          32'(e_st));
      chk("rnd_rd",         32'(bus.o_rd),             32'(e_rd));
      chk("rnd_store_data", bus.o_store_data,          e_sd);
    end

    // ---- report ----
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
